// File: rtl/t_stream_buffer_pkg.sv
// Shared constants and state encoding for the T stream buffer.
// Also provides the legacy define header values used by the PE array.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif
`ifndef PE_Array_size
`define PE_Array_size 4
`endif
`ifndef PE_Array_size_log
`define PE_Array_size_log 2
`endif
`ifndef TBUF_DEPTH
`define TBUF_DEPTH 1024
`endif
`ifndef TBUF_DEPTH_LOG
`define TBUF_DEPTH_LOG 10
`endif

package t_stream_buffer_pkg;

  localparam int TBUF_DEPTH     = `TBUF_DEPTH;
  localparam int TBUF_DEPTH_LOG = `TBUF_DEPTH_LOG;
  localparam int TBUF_VEF_BIT   = `V_E_F_Bit;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SERVE   = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_READY   = 3'd4
  } tbuf_state_e;

endpackage

// File: rtl/t_stream_buffer_if.sv
// Data-path bundle of the T stream buffer: host load stream, array output
// stream and array write-back.
interface t_stream_buffer_if #(
  parameter int VEF_BIT = t_stream_buffer_pkg::TBUF_VEF_BIT
);
  logic [1:0]         i_host_t;
  logic               i_host_valid;
  logic               o_host_ready;
  logic               i_update_t_w;
  logic               o_valid;
  logic [1:0]         o_t;
  logic [VEF_BIT-1:0] o_v;
  logic [VEF_BIT-1:0] o_f;
  logic               o_t_last;
  logic [1:0]         i_t;
  logic [VEF_BIT-1:0] i_v;
  logic [VEF_BIT-1:0] i_f;
  logic               i_t_valid;

  modport slave (
    input  i_host_t, i_host_valid, i_update_t_w, i_t, i_v, i_f, i_t_valid,
    output o_host_ready, o_valid, o_t, o_v, o_f, o_t_last
  );

  modport master (
    output i_host_t, i_host_valid, i_update_t_w, i_t, i_v, i_f, i_t_valid,
    input  o_host_ready, o_valid, o_t, o_v, o_f, o_t_last
  );
endinterface

// File: rtl/tbuf_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module tbuf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 34
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_r [DEPTH];

  // Storage write and registered read-first read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end
endmodule

// File: rtl/t_stream_buffer.sv
// T stream buffer: loads T from the host, streams {t,v,f} to the PE array and
// captures the written-back boundary for the next pass. TBUF_PASS_CNT_EN adds o_pass_cnt.
module t_stream_buffer
  import t_stream_buffer_pkg::*;
#(
  parameter int DEPTH     = TBUF_DEPTH,
  parameter int DEPTH_LOG = TBUF_DEPTH_LOG,
  parameter int VEF_BIT   = TBUF_VEF_BIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [DEPTH_LOG:0] i_t_len,
  input  logic               i_rewind,
  input  logic               i_finish,
  output logic               o_busy,
  output logic               o_overflow,
`ifdef TBUF_PASS_CNT_EN
  output logic [15:0]        o_pass_cnt,
`endif
  t_stream_buffer_if.slave   bus
);
  localparam int PW = DEPTH_LOG + 1;
  localparam int EW = 2 + 2 * VEF_BIT;
  localparam logic [DEPTH_LOG:0] LEN_MAX = PW'(DEPTH);
  localparam logic [DEPTH_LOG:0] PTR_ZERO = PW'(0);
  localparam logic [DEPTH_LOG:0] PTR_ONE = PW'(1);

  tbuf_state_e        state_r;
  logic [DEPTH_LOG:0] len_r, wr_ptr_r, rd_ptr_r, cons_cnt_r, s1_idx_r;
  logic               s1_valid_r, valid_r, last_r, host_ready_r, busy_r, overflow_r;
  logic [1:0]         t_r;
  logic [VEF_BIT-1:0] v_r, f_r;
`ifdef TBUF_PASS_CNT_EN
  logic [15:0]        pass_cnt_r;
`endif

  logic [DEPTH_LOG:0] len_in_s;
  logic               consume_s, out_adv_s, rd_issue_s, ram_we_s, wb_hit_s, wb_drop_s;
  logic [EW-1:0]      ram_wdata_s, ram_q_s;

  // Length clamp, read scheduling and RAM write-port selection
  always_comb begin
    len_in_s    = LEN_MAX;
    consume_s   = bus.i_update_t_w & valid_r;
    out_adv_s   = ~valid_r | consume_s;
    rd_issue_s  = 1'b0;
    ram_we_s    = 1'b0;
    ram_wdata_s = {bus.i_host_t, {(2 * VEF_BIT){1'b0}}};
    wb_hit_s    = 1'b0;
    wb_drop_s   = 1'b0;
    if (i_t_len == PTR_ZERO || i_t_len > LEN_MAX) begin
      len_in_s = LEN_MAX;
    end else begin
      len_in_s = i_t_len;
    end
    case (state_r)
      ST_LOAD: begin
        ram_we_s = bus.i_host_valid;
      end
      ST_SERVE, ST_WAIT_WB: begin
        // Prefetch whenever the RAM output stage will be free next cycle
        if (state_r == ST_SERVE && rd_ptr_r < len_r) begin
          rd_issue_s = ~s1_valid_r | out_adv_s;
        end else begin
          rd_issue_s = 1'b0;
        end
        // A write may only land on an entry the array has already consumed
        if (bus.i_t_valid) begin
          if (wr_ptr_r >= cons_cnt_r) begin
            wb_drop_s = 1'b1;
          end else begin
            wb_hit_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_wdata_s = {bus.i_t, bus.i_v, bus.i_f};
          end
        end else begin
          wb_hit_s = 1'b0;
        end
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  tbuf_ram #(
    .DEPTH (DEPTH),
    .AW    (DEPTH_LOG),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_r[DEPTH_LOG-1:0]),
    .wdata (ram_wdata_s),
    .re    (rd_issue_s),
    .raddr (rd_ptr_r[DEPTH_LOG-1:0]),
    .rdata (ram_q_s)
  );

  // Control FSM, read pipeline and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      len_r        <= PTR_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      cons_cnt_r   <= PTR_ZERO;
      s1_idx_r     <= PTR_ZERO;
      s1_valid_r   <= 1'b0;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      t_r          <= 2'd0;
      v_r          <= {VEF_BIT{1'b0}};
      f_r          <= {VEF_BIT{1'b0}};
      host_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
`ifdef TBUF_PASS_CNT_EN
      pass_cnt_r   <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r      <= ST_LOAD;
            len_r        <= len_in_s;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            cons_cnt_r   <= PTR_ZERO;
            overflow_r   <= 1'b0;
            host_ready_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef TBUF_PASS_CNT_EN
            pass_cnt_r   <= 16'd0;
`endif
          end
        end
        ST_LOAD: begin
          if (bus.i_host_valid) begin
            if (wr_ptr_r == len_r - PTR_ONE) begin
              state_r      <= ST_SERVE;
              wr_ptr_r     <= PTR_ZERO;
              rd_ptr_r     <= PTR_ZERO;
              cons_cnt_r   <= PTR_ZERO;
              s1_valid_r   <= 1'b0;
              host_ready_r <= 1'b0;
            end else begin
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
          end
        end
        ST_SERVE, ST_WAIT_WB: begin
          if (wb_hit_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
          end
          if (wb_drop_s) begin
            overflow_r <= 1'b1;
          end
          if (rd_issue_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            s1_idx_r   <= rd_ptr_r;
            s1_valid_r <= 1'b1;
          end else if (out_adv_s) begin
            s1_valid_r <= 1'b0;
          end
          if (out_adv_s) begin
            valid_r <= s1_valid_r;
            last_r  <= s1_valid_r && (s1_idx_r == len_r - PTR_ONE);
            if (s1_valid_r) begin
              t_r <= ram_q_s[EW-1 -: 2];
              v_r <= ram_q_s[2*VEF_BIT-1 -: VEF_BIT];
              f_r <= ram_q_s[VEF_BIT-1:0];
            end
          end
          if (consume_s) begin
            cons_cnt_r <= cons_cnt_r + PTR_ONE;
          end
          if (consume_s && last_r) begin
            state_r <= ST_WAIT_WB;
`ifdef TBUF_PASS_CNT_EN
            if (pass_cnt_r != 16'hFFFF) begin
              pass_cnt_r <= pass_cnt_r + 16'd1;
            end
`endif
          end else if (state_r == ST_WAIT_WB && wr_ptr_r == len_r) begin
            state_r <= ST_READY;
          end
        end
        ST_READY: begin
          if (i_finish) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (i_rewind) begin
            state_r    <= ST_SERVE;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            cons_cnt_r <= PTR_ZERO;
            s1_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_host_ready = host_ready_r;
  assign bus.o_valid      = valid_r;
  assign bus.o_t          = t_r;
  assign bus.o_v          = v_r;
  assign bus.o_f          = f_r;
  assign bus.o_t_last     = last_r;
  assign o_busy           = busy_r;
  assign o_overflow       = overflow_r;
`ifdef TBUF_PASS_CNT_EN
  assign o_pass_cnt       = pass_cnt_r;
`endif

endmodule

// File: tb/tb_t_stream_buffer.sv
// Directed self-checking bench for t_stream_buffer.
module tb_t_stream_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [10:0] i_t_len;
  logic        i_rewind;
  logic        i_finish;
  logic        o_busy;
  logic        o_overflow;
`ifdef TBUF_PASS_CNT_EN
  logic [15:0] o_pass_cnt;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  t_stream_buffer_if #(.VEF_BIT(16)) bus ();

  t_stream_buffer #(.DEPTH(1024), .DEPTH_LOG(10), .VEF_BIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_t_len    (i_t_len),
    .i_rewind   (i_rewind),
    .i_finish   (i_finish),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
`ifdef TBUF_PASS_CNT_EN
    .o_pass_cnt (o_pass_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_entry(input string tag, input int t, input int v, input int f, input int last);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, "_t"}, 32'(bus.o_t), 32'(t));
    check({tag, "_v"}, 32'(bus.o_v), 32'(v));
    check({tag, "_f"}, 32'(bus.o_f), 32'(f));
    check({tag, "_last"}, 32'(bus.o_t_last), 32'(last));
  endtask

  task automatic wb_beat(input int t, input int v, input int f);
    bus.i_t       = 2'(t);
    bus.i_v       = 16'(v);
    bus.i_f       = 16'(f);
    bus.i_t_valid = 1'b1;
    tick();
  endtask

  task automatic host_beat(input int t);
    bus.i_host_t     = 2'(t);
    bus.i_host_valid = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;
    int last_t;
    rst_n = 1'b0; i_start = 1'b0; i_t_len = 11'd0; i_rewind = 1'b0; i_finish = 1'b0;
    bus.i_host_t = 2'd0; bus.i_host_valid = 1'b0; bus.i_update_t_w = 1'b0;
    bus.i_t = 2'd0; bus.i_v = 16'd0; bus.i_f = 16'd0; bus.i_t_valid = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_hrdy", 32'(bus.o_host_ready), 32'd0);
    check("rst_last", 32'(bus.o_t_last), 32'd0);
    rst_n = 1'b1;
    tick();

    // Job 1: len 4, T = 0,1,2,3
    i_t_len = 11'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("load_hrdy", 32'(bus.o_host_ready), 32'd1);
    check("load_busy", 32'(o_busy), 32'd1);
    bus.i_update_t_w = 1'b1;
    for (int k = 0; k < 4; k++) host_beat(k);
    bus.i_host_valid = 1'b0;
    check("serve_hrdy", 32'(bus.o_host_ready), 32'd0);
    tick();
    check("lat1_valid", 32'(bus.o_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_entry("p1", k, 0, 0, (k == 3) ? 1 : 0);
    end
    tick();
    check("p1_end_valid", 32'(bus.o_valid), 32'd0);
    check("p1_end_busy", 32'(o_busy), 32'd1);
`ifdef TBUF_PASS_CNT_EN
    check("pass_cnt", 32'(o_pass_cnt), 32'd1);
`endif
    for (int k = 0; k < 4; k++) wb_beat(k, 10 + k, 20 + k);
    bus.i_t_valid = 1'b0;
    check("wb1_ovf", 32'(o_overflow), 32'd0);
    tick();

    // Pass 2 replays written-back data
    i_rewind = 1'b1;
    tick();
    i_rewind = 1'b0;
    tick();
    check("p2_lat1", 32'(bus.o_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_entry("p2", k, 10 + k, 20 + k, (k == 3) ? 1 : 0);
    end
    tick();
    check("p2_end_valid", 32'(bus.o_valid), 32'd0);
    for (int k = 0; k < 4; k++) wb_beat(k, 30 + k, 40 + k);
    bus.i_t_valid = 1'b0;
    tick();

    // Pass 3: consume strobe toggles, stream must stall without loss
    bus.i_update_t_w = 1'b0;
    i_rewind = 1'b1;
    tick();
    i_rewind = 1'b0;
    tick(); tick();
    expect_entry("p3_0", 0, 30, 40, 0);
    for (int j = 0; j < 6; j++) begin
      bus.i_update_t_w = (j % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      expect_entry("p3_tog", j / 2 + 1, 30 + j / 2 + 1, 40 + j / 2 + 1, (j / 2 + 1 == 3) ? 1 : 0);
    end
    bus.i_update_t_w = 1'b1;
    tick();
    check("p3_end_valid", 32'(bus.o_valid), 32'd0);
    for (int k = 0; k < 4; k++) wb_beat(k, 50 + k, 60 + k);
    bus.i_t_valid = 1'b0;
    tick();

    // Pass 4: write-back before anything is consumed is a hazard
    bus.i_update_t_w = 1'b0;
    i_rewind = 1'b1;
    tick();
    i_rewind = 1'b0;
    wb_beat(3, 99, 99);
    bus.i_t_valid = 1'b0;
    check("hazard_ovf", 32'(o_overflow), 32'd1);
    tick();
    expect_entry("p4_0", 0, 50, 60, 0);
    bus.i_update_t_w = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      expect_entry("p4", k, 50 + k, 60 + k, (k == 3) ? 1 : 0);
    end
    tick();
    for (int k = 0; k < 4; k++) wb_beat(k, 70 + k, 80 + k);
    bus.i_t_valid = 1'b0;
    tick();
    check("ready_ovf_sticky", 32'(o_overflow), 32'd1);

    // Pass 5: reset while entry 2 is presented
    i_rewind = 1'b1;
    tick();
    i_rewind = 1'b0;
    tick(); tick();
    expect_entry("p5_0", 0, 70, 80, 0);
    tick(); tick();
    expect_entry("p5_2", 2, 72, 82, 0);
    rst_n = 1'b0;
    tick();
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_valid", 32'(bus.o_valid), 32'd0);
    check("mrst_ovf", 32'(o_overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Job 2: len 2 after reset, over-length write-back
    i_t_len = 11'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    host_beat(2);
    host_beat(1);
    bus.i_host_valid = 1'b0;
    tick();
    check("j2_lat1", 32'(bus.o_valid), 32'd0);
    tick();
    expect_entry("j2_0", 2, 0, 0, 0);
    tick();
    expect_entry("j2_1", 1, 0, 0, 1);
    tick();
    check("j2_end_valid", 32'(bus.o_valid), 32'd0);
    wb_beat(2, 5, 6);
    wb_beat(1, 7, 8);
    check("j2_wb_ovf", 32'(o_overflow), 32'd0);
    wb_beat(0, 1, 1);
    bus.i_t_valid = 1'b0;
    check("j2_extra_ovf", 32'(o_overflow), 32'd1);
    tick();
    i_rewind = 1'b1; i_finish = 1'b1;
    tick();
    i_rewind = 1'b0; i_finish = 1'b0;
    check("fin_busy", 32'(o_busy), 32'd0);
    check("fin_valid", 32'(bus.o_valid), 32'd0);
    tick(); tick();
    check("fin_idle_valid", 32'(bus.o_valid), 32'd0);

    // Job 3: length 0 clamps to full depth
    i_t_len = 11'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 1023; k++) host_beat(k % 4);
    check("clamp_hrdy_mid", 32'(bus.o_host_ready), 32'd1);
    host_beat(3);
    bus.i_host_valid = 1'b0;
    check("clamp_hrdy_end", 32'(bus.o_host_ready), 32'd0);
    cnt = 0;
    last_t = -1;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus.o_valid) cnt++;
      if (bus.o_t_last) begin
        last_t = int'(bus.o_t);
        break;
      end
    end
    check("clamp_count", 32'(cnt), 32'd1024);
    check("clamp_last_t", 32'(last_t), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
